// File: rtl/conv33_tap_seq.sv
// rtl/conv33_tap_seq.sv - 3x3 convolution tap sequencer with one shared multiplier
// Nine kernel weights and one captured window; one tap is multiply-accumulated per RUN cycle.
module conv33_tap_seq #(
    parameter int DW = 6,
    parameter int OW = 18
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            k_wr_en,
    input  logic [3:0]      k_wr_addr,
    input  logic [DW-1:0]   k_wr_data,
    output logic            k_wr_drop,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [9*DW-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OW-1:0]   out_data,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [DW-1:0]   win  [9];
    logic [DW-1:0]   kern [9];
    logic [OW-1:0]   acc;
    logic [3:0]      tap;
    logic [DW-1:0]   win_sel;
    logic [DW-1:0]   kern_sel;
    logic [2*DW-1:0] prod;
    logic            accept;
    logic            k_addr_ok;
    logic            k_wr_ok;
    logic            k_wr_bad;

    assign accept    = (state == IDLE) && in_valid;
    assign k_addr_ok = (k_wr_addr <= 4'd8);
    // Weights are frozen only while a window is being accumulated.
    assign k_wr_ok   = k_wr_en && k_addr_ok && (state != RUN);
    assign k_wr_bad  = k_wr_en && !(k_addr_ok && (state != RUN));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = acc;

    always_comb begin
        win_sel  = '0;
        kern_sel = '0;
        for (int i = 0; i < 9; i++) begin
            if (tap == 4'(i)) begin
                win_sel  = win[i];
                kern_sel = kern[i];
            end
        end
    end

    assign prod = {{DW{1'b0}}, win_sel} * {{DW{1'b0}}, kern_sel};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)      state_nxt = RUN;
            RUN:     if (tap == 4'd8)   state_nxt = DONE;
            DONE:    if (out_ready)     state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            tap       <= '0;
            k_wr_drop <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win[i]  <= '0;
                kern[i] <= '0;
            end
        end else begin
            state     <= state_nxt;
            k_wr_drop <= k_wr_bad;
            if (k_wr_ok) begin
                for (int i = 0; i < 9; i++) begin
                    if (k_wr_addr == 4'(i)) kern[i] <= k_wr_data;
                end
            end
            if (accept) begin
                for (int i = 0; i < 9; i++) begin
                    win[i] <= in_data[DW*i +: DW];
                end
                acc <= '0;
                tap <= '0;
            end else if (state == RUN) begin
                // OW >= 2*DW+4 leaves headroom for nine full-scale products.
                acc <= acc + {{(OW-2*DW){1'b0}}, prod};
                tap <= tap + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_conv33_tap_seq.sv
// tb/tb_conv33_tap_seq.sv - directed self-checking bench for conv33_tap_seq
module tb_conv33_tap_seq;

    localparam int DW = 6;
    localparam int OW = 18;

    logic            clk = 1'b0;
    logic            rst;
    logic            k_wr_en;
    logic [3:0]      k_wr_addr;
    logic [DW-1:0]   k_wr_data;
    logic            k_wr_drop;
    logic            in_valid;
    logic            in_ready;
    logic [9*DW-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [OW-1:0]   out_data;
    logic            busy;

    int n_tests = 0;
    int n_fail  = 0;

    conv33_tap_seq #(.DW(DW), .OW(OW)) dut (
        .clk       (clk),
        .rst       (rst),
        .k_wr_en   (k_wr_en),
        .k_wr_addr (k_wr_addr),
        .k_wr_data (k_wr_data),
        .k_wr_drop (k_wr_drop),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [9*DW-1:0] ramp(input int base, input int step);
        logic [9*DW-1:0] w;
        w = '0;
        for (int i = 0; i < 9; i++) w[DW*i +: DW] = DW'(base + step * i);
        return w;
    endfunction

    task automatic write_k(input int addr, input int data);
        k_wr_en   = 1'b1;
        k_wr_addr = 4'(addr);
        k_wr_data = DW'(data);
        tick;
        k_wr_en   = 1'b0;
    endtask

    task automatic accept(input logic [9*DW-1:0] w);
        in_valid = 1'b1;
        in_data  = w;
        tick;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            tick;
            n++;
        end
        check("wait_out_valid", 32'(out_valid), 1);
    endtask

    initial begin
        int              n;
        int              na;
        int              nres;
        int              acc_t [2];
        logic [OW-1:0]   res [2];
        logic [OW-1:0]   hold;
        logic            acc_now;
        logic            seen;
        logic [9*DW-1:0] w;

        rst = 1'b1; k_wr_en = 1'b0; k_wr_addr = '0; k_wr_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        tick; tick;
        rst = 1'b0;
        check("rst_in_ready",  32'(in_ready),  1);
        check("rst_busy",      32'(busy),      0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data",  32'(out_data),  0);
        check("rst_k_wr_drop", 32'(k_wr_drop), 0);

        // all-63 window and weights, full-scale result and latency
        for (int i = 0; i < 9; i++) write_k(i, 63);
        check("wr63_no_drop", 32'(k_wr_drop), 0);
        accept(ramp(63, 0));
        check("run_busy",     32'(busy),     1);
        check("run_in_ready", 32'(in_ready), 0);
        wait_valid(n);
        check("max_latency",  32'(n + 1),    10);
        check("max_out_data", 32'(out_data), 35721);
        tick;
        check("max_back_idle",  32'(in_ready),  1);
        check("max_valid_drop", 32'(out_valid), 0);

        // center-only kernel, back-to-back windows with in_data changing after acceptance
        for (int i = 0; i < 9; i++) write_k(i, (i == 4) ? 1 : 0);
        in_valid = 1'b1; in_data = ramp(10, 1); out_ready = 1'b1;
        na = 0; nres = 0; acc_t[0] = 0; acc_t[1] = 0; res[0] = '0; res[1] = '0;
        for (int t = 0; t < 30; t++) begin
            acc_now = in_ready && in_valid;
            tick;
            if (acc_now) begin
                acc_t[na] = t;
                na++;
                if (na == 1) in_data = ramp(20, 1);
                else         in_valid = 1'b0;
            end
            if (out_valid && nres < 2) begin
                res[nres] = out_data;
                nres++;
            end
        end
        check("b2b_accepts",  32'(na),                2);
        check("b2b_spacing",  32'(acc_t[1] - acc_t[0]), 11);
        check("b2b_results",  32'(nres),              2);
        check("b2b_res0",     32'(res[0]),            14);
        check("b2b_res1",     32'(res[1]),            24);

        // backpressure in DONE for 20 cycles
        out_ready = 1'b0;
        accept(ramp(33, 1));
        wait_valid(n);
        hold = out_data;
        check("bp_out_data", 32'(hold), 37);
        for (int i = 0; i < 20; i++) begin
            tick;
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_stable",    32'(out_data),  32'(hold));
            check("bp_in_ready",  32'(in_ready),  0);
        end
        out_ready = 1'b1;
        tick;
        check("bp_release_idle",  32'(in_ready),  1);
        check("bp_release_valid", 32'(out_valid), 0);

        // weight write coinciding with window acceptance takes effect
        k_wr_en = 1'b1; k_wr_addr = 4'd0; k_wr_data = 6'd5;
        in_valid = 1'b1; in_data = ramp(1, 0);
        tick;
        k_wr_en = 1'b0; in_valid = 1'b0;
        check("same_cycle_no_drop", 32'(k_wr_drop), 0);
        wait_valid(n);
        check("same_cycle_result", 32'(out_data), 6);
        tick;

        // write during RUN and write to an invalid address are dropped
        for (int i = 0; i < 9; i++) write_k(i, i + 1);
        accept(ramp(2, 0));
        tick; tick;
        write_k(2, 50);
        check("run_wr_drop", 32'(k_wr_drop), 1);
        wait_valid(n);
        check("run_wr_drop_pulse", 32'(k_wr_drop), 0);
        check("run_wr_result",     32'(out_data),  90);
        tick;
        write_k(12, 7);
        check("bad_addr_drop", 32'(k_wr_drop), 1);
        tick;
        check("bad_addr_pulse", 32'(k_wr_drop), 0);
        w = '0;
        w[DW*2 +: DW] = 6'd1;
        accept(w);
        wait_valid(n);
        check("kern2_unchanged", 32'(out_data), 3);
        tick;

        // reset during RUN tap 5 abandons the window and clears the weights
        for (int i = 0; i < 9; i++) write_k(i, 63);
        accept(ramp(63, 0));
        repeat (5) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("mid_rst_in_ready",  32'(in_ready),  1);
        check("mid_rst_busy",      32'(busy),      0);
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_out_data",  32'(out_data),  0);
        seen = 1'b0;
        repeat (15) begin
            tick;
            if (out_valid) seen = 1'b1;
        end
        check("mid_rst_no_emit", 32'(seen), 0);
        accept(ramp(63, 0));
        wait_valid(n);
        check("mid_rst_kern_zero", 32'(out_data), 0);
        tick;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
